alu_seq: RTL and testbench

Registered, parametrised ALU with a valid/ready handshake on both sides and an iterative multi-cycle divider. It keeps the opcode map of the team's combinational ALU, adds a result accumulator for increment and decrement, and adds an explicit error indication for invalid opcodes and division by zero. It sits between an operand source, such as a register file or sequencer, and a result sink, and processes one operation at a time.

---
 rtl/alu_seq_pkg.sv | 35 +++
 rtl/alu_seq_div.sv | 75 +++++++
 rtl/alu_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared definitions for the sequential ALU: opcode map, FSM
//               state type and bit positions inside the flags vector.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Opcode map; 11..15 are invalid
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_MOD = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_INC = 4'd9;
    localparam logic [3:0] OP_DEC = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // flags = {carry, zero, overflow}
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/alu_seq_div.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_div
// Description : Iterative unsigned restoring divider, one quotient bit per
//               clock. A start pulse loads the operands; WIDTH steps follow.
//               done is high in the cycle of the last step, and quotient /
//               remainder then present that step's combinational result so
//               the caller can register it on the same edge.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               start          - load dividend/divisor and begin
//               dividend       - numerator
//               divisor        - denominator (caller guarantees non-zero)
//               done           - final step is being taken this cycle
//               quotient       - quotient, valid while done is high
//               remainder      - remainder, valid while done is high
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fit;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    // Partial remainder is always below the divisor, so the trial
    // difference fits in WIDTH+1 bits and its MSB is the borrow.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_dvs};
    assign w_fit     = ~w_trial[WIDTH];
    assign w_rem_nxt = w_fit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_fit};

    assign done      = (r_cnt == CW'(1));
    assign quotient  = w_quo_nxt;
    assign remainder = w_rem_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (start) begin
            r_cnt <= CW'(WIDTH);
            r_rem <= '0;
            r_quo <= dividend;
            r_dvs <= divisor;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Registered ALU with valid/ready handshake on both sides,
//               an accumulator for increment/decrement, an iterative divider
//               and an error qualifier for invalid opcodes and divide by 0.
// Config      : define ALU_SEQ_FLAGS_EN to add the flags output
//               {carry, zero, overflow}.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               in_valid/in_ready- request handshake
//               a, b, func       - operands and opcode (captured on accept)
//               out_valid/out_ready - result handshake
//               out, err         - result and its error qualifier
//               flags            - status bits (ALU_SEQ_FLAGS_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             err
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic [2:0]       flags
`endif
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;

    logic             w_accept;
    logic             w_go_div;
    logic             w_div_done;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_div_res;

    logic [WIDTH-1:0] w_sc_out;
    logic             w_sc_err;

    logic [WIDTH-1:0] r_out;
    logic             r_err;
    logic [WIDTH-1:0] r_acc;
    logic             r_is_mod;

    // Division by zero stays on the single-cycle path
    assign w_go_div = ((func == OP_DIV) || (func == OP_MOD)) && (b != '0);
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = w_go_div ? ST_DIV : ST_HOLD;
                end
            end
            ST_DIV: begin
                if (w_div_done) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_state_nxt = w_go_div ? ST_DIV : ST_HOLD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    alu_seq_div #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_accept && w_go_div),
        .dividend  (a),
        .divisor   (b),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    assign w_div_res = r_is_mod ? w_rem : w_quo;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_sc_out = '0;
        w_sc_err = 1'b0;
        case (func)
            OP_ADD: w_sc_out = a + b;
            OP_SUB: w_sc_out = a - b;
            OP_AND: w_sc_out = a & b;
            OP_MUL: w_sc_out = a * b;
            // Opcodes 4/5 only reach this path with b == 0
            OP_DIV: begin
                w_sc_out = '1;
                w_sc_err = 1'b1;
            end
            OP_MOD: begin
                w_sc_out = a;
                w_sc_err = 1'b1;
            end
            OP_XOR: w_sc_out = a ^ b;
            OP_SHL: w_sc_out = {a[WIDTH-2:0], 1'b0};
            OP_SHR: w_sc_out = {1'b0, a[WIDTH-1:1]};
            OP_INC: w_sc_out = r_acc + c_one;
            OP_DEC: w_sc_out = r_acc - c_one;
            default: begin
                w_sc_out = '0;
                w_sc_err = 1'b1;
            end
        endcase
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic [2*WIDTH-1:0] w_prod_x;
    logic [2:0]         w_sc_flags;
    logic [2:0]         r_flags;

    assign w_prod_x = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    always_comb begin
        w_sc_flags = '0;
        case (func)
            // An unsigned sum wrapped iff it is smaller than an operand
            OP_ADD: w_sc_flags[FLAG_C] = (w_sc_out < a);
            OP_SUB: w_sc_flags[FLAG_C] = (a < b);
            OP_MUL: w_sc_flags[FLAG_V] = ((w_prod_x >> WIDTH) != '0);
            OP_SHL: w_sc_flags[FLAG_C] = a[WIDTH-1];
            OP_SHR: w_sc_flags[FLAG_C] = a[0];
            OP_INC: w_sc_flags[FLAG_V] = (r_acc == '1);
            OP_DEC: w_sc_flags[FLAG_V] = (r_acc == '0);
            default: w_sc_flags = '0;
        endcase
        w_sc_flags[FLAG_Z] = (w_sc_out == '0);
        if (w_sc_err) begin
            w_sc_flags = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '0;
        end else if (w_accept && !w_go_div) begin
            r_flags <= w_sc_flags;
        end else if ((r_state == ST_DIV) && w_div_done) begin
            r_flags <= {1'b0, (w_div_res == '0), 1'b0};
        end
    end

    assign flags = r_flags;
`endif

    // ------------------------------------------------------------------
    // Output register and accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out    <= '0;
            r_err    <= 1'b0;
            r_acc    <= '0;
            r_is_mod <= 1'b0;
        end else if (w_accept && !w_go_div) begin
            r_out <= w_sc_out;
            r_err <= w_sc_err;
            if (!w_sc_err) begin
                r_acc <= w_sc_out;
            end
        end else if (w_accept) begin
            r_is_mod <= (func == OP_MOD);
        end else if ((r_state == ST_DIV) && w_div_done) begin
            r_out <= w_div_res;
            r_err <= 1'b0;
            r_acc <= w_div_res;
        end
    end

    assign out = r_out;
    assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq (WIDTH=8). Expected
//               values are hand-computed constants. Flag checks are compiled
//               in when ALU_SEQ_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       func;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_w;
    logic             err;
`ifdef ALU_SEQ_FLAGS_EN
    logic [2:0]       flags;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(
        .WIDTH (WIDTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .func      (func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_w),
        .err       (err)
`ifdef ALU_SEQ_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, then present one request for one edge
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_, input logic [3:0] tf);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        if (w >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_;
        func     = tf;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = 8'hA5;
        b        = 8'h5A;
        func     = 4'd15;
    endtask

    task automatic chk_res(input string tag, input logic [7:0] eo, input logic ee);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_out"},   32'(out_w),     32'(eo));
        chk({tag, "_err"},   32'(err),       32'(ee));
    endtask

`ifdef ALU_SEQ_FLAGS_EN
    task automatic chk_flags(input string tag, input logic [2:0] ef);
        chk({tag, "_flags"}, 32'(flags), 32'(ef));
    endtask
`endif

    int busy;
    int cyc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        func      = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_out",   32'(out_w),     32'd0);
        chk("rst_err",   32'(err),       32'd0);
        chk("rst_ready", 32'(in_ready),  32'd1);
`ifdef ALU_SEQ_FLAGS_EN
        chk_flags("rst", 3'b000);
`endif

        // 200 + 100 = 300 mod 256 = 44, carry out
        do_op(8'd200, 8'd100, 4'd0);
        chk_res("add", 8'd44, 1'b0);
`ifdef ALU_SEQ_FLAGS_EN
        chk_flags("add", 3'b100);
`endif

        // Back-to-back single-cycle ops
        do_op(8'h0F, 8'h3C, 4'd6);
        chk_res("xor", 8'h33, 1'b0);
        do_op(8'd20, 8'd13, 4'd3);
        chk_res("mul", 8'd4, 1'b0);   // 260 mod 256
`ifdef ALU_SEQ_FLAGS_EN
        chk_flags("mul", 3'b001);
`endif
        do_op(8'h81, 8'h00, 4'd7);
        chk_res("shl", 8'h02, 1'b0);
`ifdef ALU_SEQ_FLAGS_EN
        chk_flags("shl", 3'b100);
`endif
        do_op(8'h81, 8'h00, 4'd8);
        chk_res("shr", 8'h40, 1'b0);
        do_op(8'h55, 8'hAA, 4'd2);
        chk_res("and", 8'h00, 1'b0);
`ifdef ALU_SEQ_FLAGS_EN
        chk_flags("and", 3'b010);
`endif

        // 100 / 7 = 14, 8 busy cycles
        do_op(8'd100, 8'd7, 4'd4);
        busy = 0;
        cyc  = 0;
        while (!out_valid && cyc < 40) begin
            if (!in_ready) busy++;
            tick();
            cyc++;
        end
        chk("div_busy", 32'(busy), 32'd8);
        chk_res("div", 8'd14, 1'b0);

        // 100 % 7 = 2
        do_op(8'd100, 8'd7, 4'd5);
        busy = 0;
        cyc  = 0;
        while (!out_valid && cyc < 40) begin
            if (!in_ready) busy++;
            tick();
            cyc++;
        end
        chk("mod_busy", 32'(busy), 32'd8);
        chk_res("mod", 8'd2, 1'b0);

        // Divide by zero: single cycle, error, acc untouched (stays 2)
        do_op(8'd9, 8'd0, 4'd4);
        chk_res("div0", 8'd255, 1'b1);
`ifdef ALU_SEQ_FLAGS_EN
        chk_flags("div0", 3'b000);
`endif
        do_op(8'd9, 8'd0, 4'd5);
        chk_res("mod0", 8'd9, 1'b1);
        do_op(8'd0, 8'd0, 4'd9);
        chk_res("inc_acc", 8'd3, 1'b0);

        // Accumulator wrap both ways
        do_op(8'd0, 8'd1, 4'd1);
        chk_res("sub", 8'd255, 1'b0);
`ifdef ALU_SEQ_FLAGS_EN
        chk_flags("sub", 3'b100);
`endif
        do_op(8'd77, 8'd88, 4'd9);
        chk_res("inc_wrap", 8'd0, 1'b0);
`ifdef ALU_SEQ_FLAGS_EN
        chk_flags("inc_wrap", 3'b011);
`endif
        do_op(8'd77, 8'd88, 4'd10);
        chk_res("dec_wrap", 8'd255, 1'b0);
`ifdef ALU_SEQ_FLAGS_EN
        chk_flags("dec_wrap", 3'b001);
`endif
        tick();   // result consumed, back to IDLE

        // Invalid opcode, then a 5-cycle stall with a pending request
        out_ready = 1'b0;
        do_op(8'd1, 8'd2, 4'd12);
        in_valid = 1'b1;
        a        = 8'd5;
        b        = 8'd6;
        func     = 4'd0;
        for (int i = 0; i < 5; i++) begin
            chk_res("stall", 8'd0, 1'b1);
            chk("stall_ready", 32'(in_ready), 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
            chk_flags("stall", 3'b000);
`endif
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_res("after_stall", 8'd11, 1'b0);
        tick();

        // Reset during the 4th DIV cycle
        do_op(8'd255, 8'd2, 4'd4);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out",   32'(out_w),     32'd0);
        chk("mid_rst_err",   32'(err),       32'd0);
        chk("mid_rst_ready", 32'(in_ready),  32'd1);
        do_op(8'hF0, 8'h3C, 4'd2);
        chk_res("and_after_rst", 8'h30, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        chk("no_stale_div", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
